// File: rtl/tick_period_timer_pkg.sv
// Shared types and constants for the tick period timer.
package tick_period_timer_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic MODE_PERIODIC = 1'b0;
  localparam logic MODE_ONESHOT  = 1'b1;

  // Terminal count of the one-second timer fed by the 100 ms base tick.
  localparam int DEF_TERM_1S = 10;

endpackage

// File: rtl/tick_period_timer_if.sv
// Control/status bundle between a timer consumer (master) and the timer (slave).
interface tick_period_timer_if #(
  parameter int CNT_W = 4,
  parameter int PER_W = 8
);
  logic             tick_in;
  logic             start;
  logic             stop;
  logic             clear;
  logic             mode;
  logic [CNT_W-1:0] term_cnt;
  logic             timeout;
  logic             busy;
  logic             done;
  logic [CNT_W-1:0] count;
  logic [PER_W-1:0] per_cnt;
  logic             cfg_err;

  modport master (
    output tick_in, start, stop, clear, mode, term_cnt,
    input  timeout, busy, done, count, per_cnt, cfg_err
  );

  modport slave (
    input  tick_in, start, stop, clear, mode, term_cnt,
    output timeout, busy, done, count, per_cnt, cfg_err
  );
endinterface

// File: rtl/tick_period_timer_sat_counter.sv
// W-bit incrementer that sticks at all-ones; clear and reset both zero it.
module tick_period_timer_sat_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] value
);
  localparam logic [W-1:0] MAX = '1;
  localparam logic [W-1:0] ONE = W'(1);

  always_ff @(posedge clk) begin
    if (rst || clr)
      value <= '0;
    else if (inc && (value != MAX))
      value <= value + ONE;
  end
endmodule

// File: rtl/tick_period_timer.sv
// Programmable tick-counting timer: periodic or one-shot, with a saturating
// count of completed periods. Event priority: rst > clear > stop > start > tick.
module tick_period_timer
  import tick_period_timer_pkg::*;
#(
  parameter int CNT_W    = 4,
  parameter int DEF_TERM = DEF_TERM_1S,
  parameter int PER_W    = 8
) (
  input logic               clk,
  input logic               rst,
  tick_period_timer_if.slave tmr
);
  localparam logic [CNT_W-1:0] ONE      = CNT_W'(1);
  localparam logic [CNT_W-1:0] DEF_TERM_V = CNT_W'(DEF_TERM);

  state_t           state, stateNxt;
  logic [CNT_W-1:0] termQ, cnt, cntNxt;
  logic             modeQ;
  logic             latchCfg, perClr, perInc;
  logic             timeoutNxt, cfgErrNxt;
  logic             timeoutQ, cfgErrQ;
  logic [PER_W-1:0] perVal;

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= stateNxt;
  end

  always_comb begin
    stateNxt   = state;
    cntNxt     = cnt;
    latchCfg   = 1'b0;
    perClr     = 1'b0;
    perInc     = 1'b0;
    timeoutNxt = 1'b0;
    cfgErrNxt  = 1'b0;
    if (tmr.clear) begin
      cntNxt = '0;
      perClr = 1'b1;
    end else if (tmr.stop) begin
      // count is held so software can read where the run was stopped
      stateNxt = IDLE;
    end else if (tmr.start) begin
      if (tmr.term_cnt != '0) begin
        latchCfg = 1'b1;
        perClr   = 1'b1;
        cntNxt   = '0;
        stateNxt = RUN;
      end else begin
        cfgErrNxt = 1'b1;
      end
    end else if ((state == RUN) && tmr.tick_in) begin
      if (cnt == termQ - ONE) begin
        cntNxt     = '0;
        perInc     = 1'b1;
        timeoutNxt = 1'b1;
        stateNxt   = (modeQ == MODE_ONESHOT) ? DONE : RUN;
      end else begin
        cntNxt = cnt + ONE;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt      <= '0;
      termQ    <= DEF_TERM_V;
      modeQ    <= MODE_PERIODIC;
      timeoutQ <= 1'b0;
      cfgErrQ  <= 1'b0;
    end else begin
      cnt      <= cntNxt;
      timeoutQ <= timeoutNxt;
      cfgErrQ  <= cfgErrNxt;
      if (latchCfg) begin
        termQ <= tmr.term_cnt;
        modeQ <= tmr.mode;
      end
    end
  end

  tick_period_timer_sat_counter #(.W(PER_W)) perCnt (
    .clk   (clk),
    .rst   (rst),
    .clr   (perClr),
    .inc   (perInc),
    .value (perVal)
  );

  assign tmr.timeout = timeoutQ;
  assign tmr.cfg_err = cfgErrQ;
  assign tmr.busy    = (state == RUN);
  assign tmr.done    = (state == DONE);
  assign tmr.count   = cnt;
  assign tmr.per_cnt = perVal;
endmodule

// File: tb/tb_tick_period_timer.sv
// Vector-table bench for tick_period_timer plus a saturation run on a PER_W=2 copy.
module tb_tick_period_timer;

  typedef struct {
    string      name;
    bit         rst, tick, start, stop, clear, mode;
    logic [3:0] term;
    bit         to, busy, done;
    logic [3:0] cnt;
    logic [7:0] per;
    bit         ce;
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  vec_t tbl[$];
  vec_t expQ[$];

  tick_period_timer_if #(.CNT_W(4), .PER_W(8)) bus ();
  tick_period_timer_if #(.CNT_W(4), .PER_W(2)) bus2 ();

  tick_period_timer #(.CNT_W(4), .DEF_TERM(10), .PER_W(8)) dut (
    .clk (clk),
    .rst (rst),
    .tmr (bus)
  );

  tick_period_timer #(.CNT_W(4), .DEF_TERM(10), .PER_W(2)) dut2 (
    .clk (clk),
    .rst (rst),
    .tmr (bus2)
  );

  function automatic vec_t mk(string n, bit r, bit tk, bit st, bit sp, bit cl, bit md,
                              logic [3:0] tm, bit to, bit bz, bit dn, logic [3:0] c,
                              logic [7:0] p, bit ce);
    vec_t v;
    v.name = n; v.rst = r; v.tick = tk; v.start = st; v.stop = sp; v.clear = cl;
    v.mode = md; v.term = tm; v.to = to; v.busy = bz; v.done = dn; v.cnt = c;
    v.per = p; v.ce = ce;
    return v;
  endfunction

  task automatic chk(string n, logic [15:0] got, logic [15:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", n, got, exp);
    end
  endtask

  // Drive one cycle of inputs, queue its expectation, compare after the edge.
  task automatic applyVec(vec_t v);
    vec_t e;
    rst          = v.rst;
    bus.tick_in  = v.tick;
    bus.start    = v.start;
    bus.stop     = v.stop;
    bus.clear    = v.clear;
    bus.mode     = v.mode;
    bus.term_cnt = v.term;
    expQ.push_back(v);
    @(posedge clk);
    #1;
    e = expQ.pop_front();
    chk(e.name,
        {bus.timeout, bus.busy, bus.done, bus.count, bus.per_cnt, bus.cfg_err},
        {e.to, e.busy, e.done, e.cnt, e.per, e.ce});
  endtask

  initial begin
    bus.tick_in = 0; bus.start = 0; bus.stop = 0; bus.clear = 0; bus.mode = 0; bus.term_cnt = '0;
    bus2.tick_in = 0; bus2.start = 0; bus2.stop = 0; bus2.clear = 0; bus2.mode = 0; bus2.term_cnt = '0;

    // reset
    tbl.push_back(mk("reset0", 1,0,0,0,0,0,0,  0,0,0,0,0,0));
    tbl.push_back(mk("reset1", 1,0,0,0,0,0,0,  0,0,0,0,0,0));

    // periodic term 10, 25 ticks spaced 3 cycles
    tbl.push_back(mk("t1 start", 0,0,1,0,0,0,10, 0,1,0,0,0,0));
    for (int k = 1; k <= 25; k++) begin
      tbl.push_back(mk("t1 tick", 0,1,0,0,0,0,0, (k % 10) == 0, 1,0, 4'(k % 10), 8'(k / 10), 0));
      for (int g = 0; g < 2; g++)
        tbl.push_back(mk("t1 gap", 0,0,0,0,0,0,0, 0,1,0, 4'(k % 10), 8'(k / 10), 0));
    end

    // one-shot term 3, 5 ticks
    tbl.push_back(mk("t2 start",  0,0,1,0,0,1,3, 0,1,0,0,0,0));
    tbl.push_back(mk("t2 tick1",  0,1,0,0,0,0,0, 0,1,0,1,0,0));
    tbl.push_back(mk("t2 tick2",  0,1,0,0,0,0,0, 0,1,0,2,0,0));
    tbl.push_back(mk("t2 tick3",  0,1,0,0,0,0,0, 1,0,1,0,1,0));
    tbl.push_back(mk("t2 idle",   0,0,0,0,0,0,0, 0,0,1,0,1,0));
    tbl.push_back(mk("t2 tick4",  0,1,0,0,0,0,0, 0,0,1,0,1,0));
    tbl.push_back(mk("t2 tick5",  0,1,0,0,0,0,0, 0,0,1,0,1,0));

    // stop from DONE, start with zero terminal
    tbl.push_back(mk("t3 stop",     0,0,0,1,0,0,0, 0,0,0,0,1,0));
    tbl.push_back(mk("t3 start0",   0,0,1,0,0,0,0, 0,0,0,0,1,1));
    tbl.push_back(mk("t3 errclr",   0,0,0,0,0,0,0, 0,0,0,0,1,0));
    tbl.push_back(mk("t3 idletick", 0,1,0,0,0,0,0, 0,0,0,0,1,0));

    // clear/stop coincident with terminal tick, restart while running
    tbl.push_back(mk("t4 start",      0,0,1,0,0,0,4, 0,1,0,0,0,0));
    tbl.push_back(mk("t4 tick1",      0,1,0,0,0,0,0, 0,1,0,1,0,0));
    tbl.push_back(mk("t4 tick2",      0,1,0,0,0,0,0, 0,1,0,2,0,0));
    tbl.push_back(mk("t4 tick3",      0,1,0,0,0,0,0, 0,1,0,3,0,0));
    tbl.push_back(mk("t4 tick+clear", 0,1,0,0,1,0,0, 0,1,0,0,0,0));
    tbl.push_back(mk("t4 noto",       0,0,0,0,0,0,0, 0,1,0,0,0,0));
    tbl.push_back(mk("t4 tick1b",     0,1,0,0,0,0,0, 0,1,0,1,0,0));
    tbl.push_back(mk("t4 tick2b",     0,1,0,0,0,0,0, 0,1,0,2,0,0));
    tbl.push_back(mk("t4 tick3b",     0,1,0,0,0,0,0, 0,1,0,3,0,0));
    tbl.push_back(mk("t4 tick+stop",  0,1,0,1,0,0,0, 0,0,0,3,0,0));
    tbl.push_back(mk("t4 held",       0,0,0,0,0,0,0, 0,0,0,3,0,0));
    tbl.push_back(mk("t4 idletick",   0,1,0,0,0,0,0, 0,0,0,3,0,0));
    tbl.push_back(mk("t4 idleclear",  0,0,0,0,1,0,0, 0,0,0,0,0,0));
    tbl.push_back(mk("t4 start2",     0,0,1,0,0,0,4, 0,1,0,0,0,0));
    tbl.push_back(mk("t4 r1",         0,1,0,0,0,0,0, 0,1,0,1,0,0));
    tbl.push_back(mk("t4 r2",         0,1,0,0,0,0,0, 0,1,0,2,0,0));
    tbl.push_back(mk("t4 restart",    0,1,1,0,0,0,5, 0,1,0,0,0,0));
    for (int k = 1; k <= 4; k++)
      tbl.push_back(mk("t4 term5", 0,1,0,0,0,0,0, 0,1,0, 4'(k), 0, 0));
    tbl.push_back(mk("t4 term5 hit",  0,1,0,0,0,0,0, 1,1,0,0,1,0));
    tbl.push_back(mk("t4 after",      0,0,0,0,0,0,0, 0,1,0,0,1,0));

    // max terminal with tick held high
    tbl.push_back(mk("t5 start", 0,0,1,0,0,0,15, 0,1,0,0,0,0));
    for (int i = 1; i <= 30; i++)
      tbl.push_back(mk("t5 held", 0,1,0,0,0,0,0, (i % 15) == 0, 1,0, 4'(i % 15), 8'(i / 15), 0));
    tbl.push_back(mk("t5 release", 0,0,0,0,0,0,0, 0,1,0,0,2,0));

    // reset mid-run, and reset coincident with a terminal tick
    tbl.push_back(mk("t6 start", 0,0,1,0,0,0,10, 0,1,0,0,0,0));
    for (int k = 1; k <= 7; k++)
      tbl.push_back(mk("t6 tick", 0,1,0,0,0,0,0, 0,1,0, 4'(k), 0, 0));
    tbl.push_back(mk("t6 rst@7",    1,1,0,0,0,0,0, 0,0,0,0,0,0));
    tbl.push_back(mk("t6 start2",   0,0,1,0,0,0,2, 0,1,0,0,0,0));
    tbl.push_back(mk("t6 tick1",    0,1,0,0,0,0,0, 0,1,0,1,0,0));
    tbl.push_back(mk("t6 rst@term", 1,1,0,0,0,0,0, 0,0,0,0,0,0));
    tbl.push_back(mk("t6 post",     0,0,0,0,0,0,0, 0,0,0,0,0,0));
    tbl.push_back(mk("t6 rst end",  1,0,0,0,0,0,0, 0,0,0,0,0,0));

    foreach (tbl[i]) applyVec(tbl[i]);

    // PER_W=2 copy: term 2, five periods, per_cnt sticks at 3
    rst = 1'b0;
    bus.start = 1'b0; bus.tick_in = 1'b0;
    bus2.start = 1'b1; bus2.term_cnt = 4'd2; bus2.mode = 1'b0;
    @(posedge clk); #1;
    chk("sat start", {15'd0, bus2.busy}, 16'd1);
    bus2.start = 1'b0;
    bus2.tick_in = 1'b1;
    for (int i = 1; i <= 10; i++) begin
      int pe;
      logic [1:0] p2;
      logic       t2;
      pe = (i / 2 > 3) ? 3 : i / 2;
      p2 = 2'(pe);
      t2 = (i % 2) == 0;
      @(posedge clk); #1;
      chk("sat period", {13'd0, bus2.timeout, bus2.per_cnt}, {13'd0, t2, p2});
    end
    bus2.tick_in = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/tick_period_timer.md
Name: tick_period_timer

Overview:
- Parametrised tick-counting timer: counts single-cycle tick_in pulses from an upstream prescaler and pulses timeout when a programmable terminal count is reached.
- Successor to the fixed count-to-10 divider. Adds:
  - programmable terminal count;
  - periodic and one-shot modes;
  - start/stop/clear control;
  - visible count;
  - a saturating period counter.
- Sits between the base tick generator (e.g. the 100 ms tick) and game-level timeout consumers; instances may be chained tick-to-tick.

Parameters:
- CNT_W, 4, width of tick counter and terminal-count register.
- DEF_TERM, 10, terminal count loaded at reset; must be in 1..2^CNT_W-1.
- PER_W, 8, width of saturating completed-period counter.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous reset, active-high.
- tick_in  in  1  one-cycle count-enable pulse.
- start  in  1  one-cycle strobe: latch term_cnt and mode, zero count, enter RUN.
- stop  in  1  one-cycle strobe: return to IDLE, hold count.
- clear  in  1  one-cycle strobe: zero count and per_cnt, state unchanged.
- mode  in  1  0 = periodic, 1 = one-shot; sampled only on start.
- term_cnt  in  CNT_W  terminal count; sampled only on start.
- timeout  out  1  one-cycle pulse on reaching terminal count.
- busy  out  1  high in RUN.
- done  out  1  high in DONE (one-shot finished).
- count  out  CNT_W  current tick count.
- per_cnt  out  PER_W  completed periods since reset/clear/start, saturating.
- cfg_err  out  1  one-cycle pulse when start is given with term_cnt == 0.

Behaviour:
- Reset (rst=1 at clk edge):
  - state=IDLE; count=0; per_cnt=0.
  - timeout=0; cfg_err=0.
  - term_q=DEF_TERM; mode_q=0.
- States:
  - IDLE: ticks ignored.
    - start with term_cnt!=0: latch term_q/mode_q, count=0, per_cnt=0, go to RUN.
    - start with term_cnt==0: cfg_err=1 next cycle, stay IDLE, term_q unchanged.
  - RUN: each tick_in increments count.
    - If count==term_q-1 and tick_in: timeout=1 in the next cycle (registered, 1-cycle latency after the terminal tick), count←0, per_cnt+1 (saturate at 2^PER_W-1).
    - Then periodic mode stays in RUN; one-shot mode goes to DONE.
  - DONE: count=0, ticks ignored, done=1; start → RUN (same rules as IDLE); stop → IDLE.
- Outputs:
  - timeout and cfg_err are never high for more than one cycle per event.
  - busy=(state==RUN); done=(state==DONE); both registered.
- Priority when events coincide: rst > clear > stop > start > tick_in.
  - clear + tick in RUN: count=0, tick discarded, no timeout.
  - stop + terminal tick: no timeout, IDLE, count held at pre-stop value.
  - start while RUN: restart: relatch, count=0, per_cnt=0; coincident tick discarded.
  - clear in IDLE/DONE: zeroes counters only.
- Width rules:
  - count never exceeds term_q-1, so no wrap beyond the terminal.
  - term_q max is 2^CNT_W-1.
  - Arithmetic is unsigned and sized to CNT_W/PER_W; no truncation warnings.
- tick_in held high continuously counts once per clock (no edge detection in this block).
- Reset mid-RUN aborts immediately with no timeout.

Decomposition:
- Shared package (timer_pkg):
  - state encoding typedef {IDLE, RUN, DONE};
  - mode constants MODE_PERIODIC=0, MODE_ONESHOT=1;
  - default terminal constant (10) used for the one-second timer instance.
- Single module. An optional sub-module sat_counter (PER_W-wide saturating incrementer with clear) is natural and reusable elsewhere.

Test Plan:
- Reset, start with term_cnt=10, mode=0, 25 ticks spaced 3 cycles → timeout pulses exactly after ticks 10 and 20; per_cnt=2; count=5; busy=1.
- Start with term_cnt=3, mode=1, 5 ticks → one timeout after tick 3, done=1, busy=0, count stays 0 for ticks 4-5, per_cnt=1.
- Start with term_cnt=0 → cfg_err one-cycle pulse, state IDLE, term_q still 10.
- RUN with term_cnt=4: tick_in coincident with clear at count=3 → count=0, no timeout; coincident with stop at count=3 → no timeout, IDLE, count=3.
- CNT_W=4, term_cnt=15, tick_in held high 30 cycles → timeout on cycles 16 and 31 after the first tick; PER_W=2 run for 5 periods → per_cnt saturates at 3.
- rst asserted mid-RUN at count=7 → next cycle count=0, busy=0, timeout=0, term_q=DEF_TERM.
